// File: rtl/button_bounce_gen.sv
// Mechanical-switch emulator: turns a clean commanded level into a bouncing,
// LFSR-timed button signal so a downstream debouncer sees reproducible glitches.
module button_bounce_gen #(
   parameter int          BOUNCE_LEN  = 1000,
   parameter int          TOGGLE_LOG2 = 4,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       level_in,
   input  logic       enable,
   output logic       button_out,
   output logic       busy,
   output logic [7:0] toggles
);

   localparam int WW = (BOUNCE_LEN > 2) ? $clog2(BOUNCE_LEN) : 1;
   localparam int IW = TOGGLE_LOG2 + 1;
   localparam logic [WW-1:0] WIN_RELOAD = WW'(BOUNCE_LEN - 1);

   typedef enum logic {IDLE, BOUNCE} state_t;

   state_t        state_q, state_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [WW-1:0] window_q, window_d, win_nxt;
   logic [IW-1:0] interval_q, interval_d, iv_dec, iv_reload;
   logic          target_q, target_d;
   logic          button_q, button_d;
   logic          busy_q, busy_d;
   logic [7:0]    tog_q, tog_d, tog_inc;

   always_comb begin
      state_d    = state_q;
      window_d   = window_q;
      interval_d = interval_q;
      target_d   = target_q;
      button_d   = button_q;
      busy_d     = busy_q;
      tog_d      = tog_q;

      // Galois, shift right, taps x^16+x^14+x^13+x^11+1
      lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      iv_reload = IW'(lfsr_q[TOGGLE_LOG2-1:0]) + IW'(1);
      iv_dec    = interval_q - IW'(1);
      tog_inc   = (tog_q == 8'hFF) ? tog_q : tog_q + 8'd1;
      // A commanded change mid-window restarts the window but not the interval.
      win_nxt   = (level_in != target_q) ? WIN_RELOAD : window_q - WW'(1);

      case (state_q)
         IDLE: begin
            if (!enable) begin
               button_d = level_in;
               target_d = level_in;
            end else if (level_in != button_q) begin
               target_d   = level_in;
               button_d   = level_in;
               window_d   = WIN_RELOAD;
               interval_d = iv_reload;
               tog_d      = 8'd1;
               busy_d     = 1'b1;
               state_d    = BOUNCE;
            end
         end
         BOUNCE: begin
            if (!enable) begin
               button_d = level_in;
               target_d = level_in;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end else begin
               target_d   = level_in;
               window_d   = win_nxt;
               interval_d = iv_dec;
               if (win_nxt == '0) begin
                  button_d = target_q;
                  busy_d   = 1'b0;
                  state_d  = IDLE;
                  if (button_q != target_q) tog_d = tog_inc;
               end else if (iv_dec == '0) begin
                  button_d   = ~button_q;
                  tog_d      = tog_inc;
                  interval_d = iv_reload;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         lfsr_q     <= SEED;
         window_q   <= '0;
         interval_q <= '0;
         target_q   <= 1'b0;
         button_q   <= 1'b0;
         busy_q     <= 1'b0;
         tog_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         window_q   <= window_d;
         interval_q <= interval_d;
         target_q   <= target_d;
         button_q   <= button_d;
         busy_q     <= busy_d;
         tog_q      <= tog_d;
      end
   end

   assign button_out = button_q;
   assign busy       = busy_q;
   assign toggles    = tog_q;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Directed bench for button_bounce_gen: toggle timing predicted from an
// event-list model of the seeded LFSR, edges counted since reset release.
module tb_button_bounce_gen;
   localparam int          BL = 64;
   localparam int          TL = 3;
   localparam logic [15:0] SD = 16'hACE1;

   logic       clk = 1'b0, reset = 1'b1, level_in = 1'b0, enable = 1'b1;
   logic       button_out, busy;
   logic [7:0] toggles;

   int          checks = 0, errors = 0;
   int          ecnt;
   logic [15:0] lf [0:2047];
   logic [7:0]  t_press, t_rel, t_rev, t_abort, t_part, t_rerun;

   button_bounce_gen #(.BOUNCE_LEN(BL), .TOGGLE_LOG2(TL), .SEED(SD)) dut (
      .clk(clk), .reset(reset), .level_in(level_in), .enable(enable),
      .button_out(button_out), .busy(busy), .toggles(toggles)
   );

   always #5 clk = ~clk;

   // edges since reset release; lf[k] is the LFSR value before edge k
   always @(posedge clk or posedge reset)
      if (reset) ecnt <= 0; else ecnt <= ecnt + 1;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         chk(tag, 32'({button_out, busy, toggles}), 32'(0));
      end
   endtask

   // Check one bounce window started by a level change already driven before edge N.
   // rev_j >= 0 reverses level_in so it is sampled at edge N+rev_j; stop_j >= 0 ends early.
   task automatic win(input string tag, input bit tgt0, input int rev_j, input int stop_j,
                      output logic [7:0] tog_out);
      int         n, e, t, cnt, last_j;
      bit         tog [0:255];
      bit         fin, b;
      logic [7:0] et;
      n   = ecnt;
      tog = '{default: 0};
      e   = n + BL - 1 + ((rev_j >= 0) ? rev_j : 0);
      fin = (rev_j >= 0) ? ~tgt0 : tgt0;
      t   = n + 1 + int'(lf[n][TL-1:0]);
      while (t < e) begin
         tog[t-n] = 1'b1;
         t = t + 1 + int'(lf[t][TL-1:0]);
      end
      last_j = (stop_j >= 0) ? stop_j : e - n;
      cnt = 0;
      et  = 8'd0;
      for (int j = 0; j <= last_j; j++) begin
         if (j == rev_j && j > 0) begin
            @(negedge clk);
            level_in = ~tgt0;
         end
         @(posedge clk); #1;
         if (tog[j]) cnt++;
         if (j == e - n) begin
            b  = fin;
            et = 8'(1 + cnt + (((tgt0 ^ cnt[0]) != fin) ? 1 : 0));
         end else begin
            b  = tgt0 ^ cnt[0];
            et = 8'(1 + cnt);
         end
         chk($sformatf("%s_btn_j%0d", tag, j), 32'(button_out), 32'(b));
         chk($sformatf("%s_busy_j%0d", tag, j), 32'(busy), 32'(j < e - n));
         chk($sformatf("%s_tog_j%0d", tag, j), 32'(toggles), 32'(et));
      end
      tog_out = et;
   endtask

   initial begin
      lf[0] = SD;
      for (int k = 0; k < 2047; k++)
         lf[k+1] = {1'b0, lf[k][15:1]} ^ (lf[k][0] ? 16'hB400 : 16'h0000);

      repeat (5) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      chk("reset_state", 32'({button_out, busy, toggles}), 32'(0));
      idle("idle_after_reset", 100);

      @(negedge clk); level_in = 1'b1;
      win("press", 1'b1, -1, -1, t_press);
      @(negedge clk); level_in = 1'b0;
      win("release", 1'b0, -1, -1, t_rel);
      @(negedge clk); level_in = 1'b1;
      win("reversal", 1'b1, 20, -1, t_rev);

      // clean pass-through
      @(negedge clk); enable = 1'b0; level_in = 1'b1;
      chk("pt_not_yet", 32'(button_out), 32'(0));
      @(posedge clk); #1;
      chk("pt_rise_btn", 32'(button_out), 32'(1));
      chk("pt_rise_busy", 32'(busy), 32'(0));
      chk("pt_tog_hold", 32'(toggles), 32'(t_rev));
      @(negedge clk); level_in = 1'b0;
      @(posedge clk); #1;
      chk("pt_fall_btn", 32'(button_out), 32'(0));
      chk("pt_fall_busy", 32'(busy), 32'(0));

      // abort mid-window
      @(negedge clk); enable = 1'b1; level_in = 1'b1;
      win("abort_pre", 1'b1, -1, 10, t_abort);
      @(negedge clk); enable = 1'b0; level_in = 1'b0;
      @(posedge clk); #1;
      chk("abort_btn", 32'(button_out), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_tog_hold", 32'(toggles), 32'(t_abort));
      @(posedge clk); #1;
      chk("abort_stays_idle", 32'({button_out, busy}), 32'(0));

      // async reset mid-window, then rerun of the press scenario
      @(negedge clk); enable = 1'b1; reset = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      idle("idle_second", 100);
      @(negedge clk); level_in = 1'b1;
      win("partial", 1'b1, -1, 30, t_part);
      #3 reset = 1'b1; level_in = 1'b0;
      #1 chk("async_reset", 32'({button_out, busy, toggles}), 32'(0));
      repeat (5) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      idle("idle_third", 100);
      @(negedge clk); level_in = 1'b1;
      win("rerun", 1'b1, -1, -1, t_rerun);
      chk("rerun_same_count", 32'(toggles), 32'(t_press));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
